// File: rtl/pc_unit_stack.sv
// rtl/pc_unit_stack.sv - nRisc program counter with sequential/branch/jump and call/return stack
module pc_unit_stack #(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 1,
    localparam int              CW           = $clog2(STACK_DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             EscPC,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Offset,
    input  logic [WIDTH-1:0] EntradaPC,
    output logic [WIDTH-1:0] SaidaPC,
    output logic [CW-1:0]    StackCount,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int               AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    localparam logic [2:0] OP_SEQ    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [CW-1:0]    cnt_next;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             stack_full;
    logic             stack_empty;
    logic             do_push;
    logic             ovf_set;
    logic             unf_set;

    // Stack count doubles as the write pointer; the top entry sits one below it.
    assign pc_inc      = SaidaPC + INC_W;
    assign push_idx    = AW'(StackCount);
    assign pop_idx     = AW'(StackCount - CW'(1));
    assign stack_full  = (StackCount == CW'(STACK_DEPTH));
    assign stack_empty = (StackCount == '0);

    always_comb begin
        pc_next  = SaidaPC;
        cnt_next = StackCount;
        do_push  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (EscPC) begin
            case (Op)
                OP_SEQ:    pc_next = pc_inc;
                OP_BRANCH: pc_next = SaidaPC + Offset;
                OP_JUMP:   pc_next = EntradaPC;
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        do_push  = 1'b1;
                        cnt_next = StackCount + CW'(1);
                        pc_next  = EntradaPC;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        cnt_next = StackCount - CW'(1);
                        pc_next  = stack_mem[pop_idx];
                    end
                end
                default:   pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            SaidaPC    <= RESET_VECTOR;
            StackCount <= '0;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            SaidaPC    <= pc_next;
            StackCount <= cnt_next;
            Overflow   <= Overflow | ovf_set;
            Underflow  <= Underflow | unf_set;
        end
    end

    // Entry contents survive reset; only the count is cleared.
    always_ff @(posedge Clock) begin
        if (do_push && !Reset) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule
